sifh_hist_reader: RTL and testbench
===================================

SIFH_HIST_READER -- requirements
Module: sifh_hist_reader

Interface
REQ-001 SHALL have parameter BIN_W, default 6: histogram bin address width (2^BIN_W bins per pixel).
REQ-002 SHALL have parameter PIX_W, default 2: pixel index width (2^PIX_W pixels per RAM).
REQ-003 SHALL have parameter CNT_W, default 8: bin count width.
REQ-004 SHALL have port clk, input, 1: sole clock, all logic on its rising edge.
REQ-005 SHALL have port res, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1: request one readout pass over all pixels.
REQ-007 SHALL have port acq_active, input, 1: histogram writer FSM is accumulating.
REQ-008 SHALL have port raddr, output, PIX_W+BIN_W: RAM read address {pixel, bin}.
REQ-009 SHALL have port rEnable, output, 1: RAM read enable, active-low (0 = read).
REQ-010 SHALL have port rdata, input, CNT_W: RAM read data, valid one cycle after raddr/rEnable=0.
REQ-011 SHALL have port waddr, output, PIX_W+BIN_W: RAM clear-write address.
REQ-012 SHALL have port wEnable, output, 1: RAM write enable, active-high; write data is zero.
REQ-013 SHALL have port busy, output, 1: pass in progress.
REQ-014 SHALL have port out_valid, output, 1: peak result valid.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-016 SHALL have port out_pixel, output, PIX_W: pixel index of result.
REQ-017 SHALL have port peak_bin, output, BIN_W: bin with maximum count.
REQ-018 SHALL have port peak_count, output, CNT_W: that maximum count.
REQ-019 SHALL have port empty, output, 1: every bin of the pixel read zero.
REQ-020 SHALL have port done, output, 1: one-cycle pulse at end of pass.

Function
REQ-021 SHALL implement states IDLE, READ, DRAIN, OUT, FIN.
REQ-022 IDLE: start=1 and acq_active=0 -> READ with pixel=0, bin=0; start with acq_active=1 -> ignored, stay IDLE.
REQ-023 start SHALL be ignored in every state other than IDLE.
REQ-024 READ: each cycle drive raddr={pixel,bin}, rEnable=0, increment bin; after issuing bin 2^BIN_W-1 -> DRAIN.
REQ-025 One cycle after each read, the block SHALL compare rdata to the running max; it SHALL replace only on strictly greater, so ties keep the lowest bin.
REQ-026 In the same cycle as that compare, the block SHALL drive wEnable=1, waddr = address read the previous cycle (read-and-clear).
REQ-027 The running max SHALL initialise to count 0, bin 0 at the start of each pixel.
REQ-028 DRAIN: last compare/clear performed -> OUT.
REQ-029 OUT: out_valid=1 and result held stable; on out_valid&out_ready, last pixel -> FIN, else pixel+1, bin=0 -> READ next cycle.
REQ-030 empty SHALL be 1 iff peak_count==0; peak_bin SHALL then be 0.
REQ-031 FIN: done=1 for exactly one cycle -> IDLE.
REQ-032 busy SHALL be 1 in READ, DRAIN, OUT, FIN, and 0 in IDLE.
REQ-033 rEnable SHALL be 1 and wEnable 0 in OUT, FIN, IDLE.
REQ-034 Timing: start accepted at cycle 0 -> bin 0 read at cycle 1 -> out_valid at cycle 2^BIN_W+2 for pixel 0.
REQ-035 Counts equal to 2^CNT_W-1 SHALL compare normally, with no overflow.

Reset
REQ-036 res=0 at a clock edge SHALL force IDLE from any state; out_valid, done, busy, wEnable = 0, rEnable = 1, and raddr, waddr, out_pixel, peak_bin, peak_count, empty = 0.
REQ-037 A reset mid-pass SHALL abandon the pass with no result or done, and SHALL leave partially cleared RAM as is.

Verification
REQ-038 Pixel 0 with bin 17=200 and all else 0, BIN_W=6 -> out_valid at cycle 66, peak_bin=17, peak_count=200, empty=0, all 64 bins read back 0 afterwards.
REQ-039 Tie: bins 5 and 40 both =9 -> peak_bin=5, peak_count=9.
REQ-040 All-zero pixel -> empty=1, peak_bin=0, peak_count=0.
REQ-041 out_ready held 0 for 10 cycles in OUT -> result stable with no RAM access; 4 pixels accepted back-to-back -> out_pixel 0..3 then a single done pulse.
REQ-042 start with acq_active=1 -> busy stays 0; start pulsed during READ -> no effect.
REQ-043 res=0 mid-READ -> next cycle IDLE with all outputs at reset values; a new start completes a full pass.

Source files
------------

// File: rtl/sifh_hist_reader.sv
// Histogram readout: walks every bin of every pixel, finds the peak bin per
// pixel, and clears each bin as it is read so the RAM is ready for the next
// acquisition.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start while the writer is not accumulating
// READ  | issuing one RAM read per cycle for the current pixel
// DRAIN | last read's data arrives; final compare and clear
// OUT   | peak result presented, held until out_ready
// FIN   | one-cycle done pulse, then back to IDLE
module sifh_hist_reader #(
  parameter int BIN_W = 6,
  parameter int PIX_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   start,
  input  logic                   acq_active,
  output logic [PIX_W+BIN_W-1:0] raddr,
  output logic                   rEnable,
  input  logic [CNT_W-1:0]       rdata,
  output logic [PIX_W+BIN_W-1:0] waddr,
  output logic                   wEnable,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIX_W-1:0]       out_pixel,
  output logic [BIN_W-1:0]       peak_bin,
  output logic [CNT_W-1:0]       peak_count,
  output logic                   empty,
  output logic                   done
);

  localparam int AW = PIX_W + BIN_W;
  localparam logic [BIN_W-1:0] BIN_LAST = {BIN_W{1'b1}};
  localparam logic [PIX_W-1:0] PIX_LAST = {PIX_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_OUT,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  pix_q;
  logic [BIN_W-1:0]  bin_q;
  logic              rd_pend_q;
  logic [AW-1:0]     rd_addr_q;
  logic [CNT_W-1:0]  max_cnt_q;
  logic [BIN_W-1:0]  max_bin_q;
  logic              init_pass;
  logic              next_pixel;

  // State register
  always_ff @(posedge clk) begin
    if (!res) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and state-driven outputs
  always_comb begin
    state_d    = state_q;
    raddr      = '0;
    rEnable    = 1'b1;
    busy       = 1'b1;
    out_valid  = 1'b0;
    done       = 1'b0;
    init_pass  = 1'b0;
    next_pixel = 1'b0;
    wEnable    = rd_pend_q;
    waddr      = rd_pend_q ? rd_addr_q : '0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !acq_active) begin
          state_d   = S_READ;
          init_pass = 1'b1;
        end
      end
      S_READ: begin
        raddr   = {pix_q, bin_q};
        rEnable = 1'b0;
        if (bin_q == BIN_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (pix_q == PIX_LAST) begin
            state_d = S_FIN;
          end else begin
            state_d    = S_READ;
            next_pixel = 1'b1;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address counters, read pipeline and running maximum
  always_ff @(posedge clk) begin
    if (!res) begin
      pix_q     <= '0;
      bin_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      max_cnt_q <= '0;
      max_bin_q <= '0;
    end else begin
      rd_pend_q <= (state_q == S_READ);
      if (state_q == S_READ) begin
        rd_addr_q <= {pix_q, bin_q};
        bin_q     <= bin_q + 1'b1;
      end
      // The compare uses the bin index the data belongs to, not the current counter.
      if (rd_pend_q && (rdata > max_cnt_q)) begin
        max_cnt_q <= rdata;
        max_bin_q <= rd_addr_q[BIN_W-1:0];
      end
      if (init_pass || next_pixel) begin
        pix_q     <= init_pass ? '0 : pix_q + 1'b1;
        bin_q     <= '0;
        max_cnt_q <= '0;
        max_bin_q <= '0;
      end
      if (state_q == S_FIN) pix_q <= '0;
    end
  end

  assign out_pixel  = pix_q;
  assign peak_bin   = max_bin_q;
  assign peak_count = max_cnt_q;
  assign empty      = (state_q == S_OUT) && (max_cnt_q == '0);

endmodule

// File: tb/tb_sifh_hist_reader.sv
// Scoreboard bench for sifh_hist_reader with a behavioural RAM model.
module tb_sifh_hist_reader;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       start = 1'b0;
  logic       acq_active = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] raddr, waddr;
  logic       rEnable, wEnable;
  logic [7:0] rdata = 8'd0;
  logic       busy, out_valid, empty, done;
  logic [1:0] out_pixel;
  logic [5:0] peak_bin;
  logic [7:0] peak_count;

  sifh_hist_reader #(.BIN_W(6), .PIX_W(2), .CNT_W(8)) dut (
    .clk(clk), .res(res), .start(start), .acq_active(acq_active),
    .raddr(raddr), .rEnable(rEnable), .rdata(rdata),
    .waddr(waddr), .wEnable(wEnable), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .peak_bin(peak_bin), .peak_count(peak_count), .empty(empty), .done(done)
  );

  always #5 clk = ~clk;

  // Histogram RAM: registered read, zero-write clear
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (!rEnable) rdata <= mem[raddr];
    if (wEnable) mem[waddr] = 8'd0;
  end

  typedef struct {
    int pix;
    int bin;
    int cnt;
    int emp;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: per pixel, the first bin holding the largest count
  task automatic push_expected();
    for (int p = 0; p < 4; p++) begin
      exp_t e;
      e.pix = p; e.bin = 0; e.cnt = 0;
      for (int b = 0; b < 64; b++)
        if (int'(mem[p*64+b]) > e.cnt) begin
          e.cnt = int'(mem[p*64+b]);
          e.bin = b;
        end
      e.emp = (e.cnt == 0) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic fill(input int p, input int mode);
    for (int b = 0; b < 64; b++) begin
      case (mode)
        0: mem[p*64+b] = 8'd0;
        1: mem[p*64+b] = 8'($urandom_range(0, 255));
        2: mem[p*64+b] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
        default: mem[p*64+b] = 8'($urandom_range(254, 255));
      endcase
    end
  endtask

  // Monitor: pops the scoreboard on each accepted result, checks holds during stalls
  logic       hold_v = 1'b0;
  int         h_pix, h_bin, h_cnt, h_emp;
  always @(negedge clk) begin
    if (res && out_valid) begin
      chk("out_ren_idle", int'(rEnable), 1);
      chk("out_wen_idle", int'(wEnable), 0);
      if (hold_v) begin
        chk("stall_pixel", int'(out_pixel), h_pix);
        chk("stall_bin", int'(peak_bin), h_bin);
        chk("stall_count", int'(peak_count), h_cnt);
        chk("stall_empty", int'(empty), h_emp);
      end
      if (out_ready) begin
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", exp_q.size(), 1);
        end else begin
          e_mon = exp_q.pop_front();
          chk("res_pixel", int'(out_pixel), e_mon.pix);
          chk("res_peak_bin", int'(peak_bin), e_mon.bin);
          chk("res_peak_count", int'(peak_count), e_mon.cnt);
          chk("res_empty", int'(empty), e_mon.emp);
        end
      end else begin
        hold_v = 1'b1;
        h_pix = int'(out_pixel); h_bin = int'(peak_bin);
        h_cnt = int'(peak_count); h_emp = int'(empty);
      end
    end else begin
      hold_v = 1'b0;
    end
    if (res && done) done_cnt++;
  end

  task automatic check_reset_outputs();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wen", int'(wEnable), 0);
    chk("rst_ren", int'(rEnable), 1);
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_out_pixel", int'(out_pixel), 0);
    chk("rst_peak_bin", int'(peak_bin), 0);
    chk("rst_peak_count", int'(peak_count), 0);
    chk("rst_empty", int'(empty), 0);
  endtask

  // ready_mode: 0 always ready, 1 random, 2 first result stalled 10 cycles
  task automatic run_pass(input int ready_mode, input bit poke_start, input bit check_lat);
    int cyc, first_ov, stall_left, nz;
    bit done_seen;
    push_expected();
    done_cnt = 0;
    done_seen = 0;
    first_ov = 0;
    stall_left = (ready_mode == 2) ? 10 : 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    if (check_lat) begin
      chk("bin0_raddr", int'(raddr), 0);
      chk("bin0_ren", int'(rEnable), 0);
    end
    while (cyc < 3000) begin
      if (done) begin
        done_seen = 1;
        break;
      end
      if (out_valid) begin
        if (first_ov == 0) first_ov = cyc;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else out_ready = 1'b1;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (cyc == 5) chk("busy_in_read", int'(busy), 1);
      start = (poke_start && cyc == 10) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("pass_done_seen", int'(done_seen), 1);
    if (check_lat) chk("first_out_valid_cycle", first_ov, 66);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulse_count", done_cnt, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != 8'd0) nz++;
    chk("ram_cleared", nz, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    res = 1'b1;

    // Single peak, exact latency
    fill(0, 0); mem[17] = 8'd200;
    fill(1, 1); fill(2, 2); fill(3, 3);
    run_pass(0, 1'b0, 1'b1);

    // Tie keeps the lower bin, all-zero pixel, saturated counts, stall, start during READ
    fill(0, 0); mem[5] = 8'd9; mem[40] = 8'd9;
    fill(1, 0); fill(2, 3); fill(3, 2);
    run_pass(2, 1'b1, 1'b0);

    // start ignored while the writer is accumulating
    acq_active = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("acq_busy", int'(busy), 0);
    end
    start = 1'b0;
    acq_active = 1'b0;

    // Random passes with random backpressure
    for (int n = 0; n < 4; n++) begin
      for (int p = 0; p < 4; p++) fill(p, int'($urandom_range(0, 3)));
      run_pass(1, 1'b0, 1'b0);
    end

    // Reset mid-READ abandons the pass and leaves the rest of the RAM untouched
    for (int p = 0; p < 4; p++) fill(p, 1);
    mem[40] = 8'd77;
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1 res = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs();
    res = 1'b1;
    chk("rst_mid_done", done_cnt, 0);
    chk("rst_untouched_bin", int'(mem[40]), 77);
    chk("rst_cleared_bin", int'(mem[3]), 0);
    run_pass(1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
